eth_pcs_tx_blk_sched: RTL and testbench

- Transmit-side block scheduler between the 64b/66b encoder output and the scrambler/TX gearbox.
- Pulls one 66-bit block per gearbox block period from the encoder over a valid/ready handshake.
- Presents the block to the datapath as W_SYNC header bits plus W_DATA-wide words, aligned to the gearbox transfer counter and stalled on the gearbox pause cycle.
- Substitutes an idle control block on encoder underflow and an error control block on an illegal sync header.

---
 rtl/eth_pcs_tx_blk_sched.sv | 128 ++++++++++++
 tb/tb_eth_pcs_tx_blk_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_tx_blk_sched.sv
// 64b/66b TX block scheduler: pulls one encoder block per gearbox block period and serves it as sync + W_DATA words.
// Latency: a block accepted at the load point (last transfer) is on o_data from the next enabled transfer 0.
// Backpressure: o_blk_ready is high only at the load point; idle/error blocks are substituted, never stalling.
// Optional: define ETH_TX_SCHED_LPI_EN to add i_lpi_req (LPI block substitution, encoder not taken).
module eth_pcs_tx_blk_sched #(
  parameter int W_DATA          = 32,
  parameter int W_SYNC          = 2,
  parameter int N_TRANS         = 2,
  parameter int W_TRANS_PER_BLK = 1,
  parameter int W_UFL_CNT       = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clk_en,
  input  logic [W_TRANS_PER_BLK-1:0]  i_trans_cnt,
  input  logic                        i_blk_valid,
  input  logic [W_SYNC-1:0]           i_blk_sync,
  input  logic [W_DATA*N_TRANS-1:0]   i_blk_data,
`ifdef ETH_TX_SCHED_LPI_EN
  input  logic                        i_lpi_req,
`endif
  output logic                        o_blk_ready,
  output logic [W_SYNC-1:0]           o_sync_data,
  output logic [W_DATA-1:0]           o_data,
  output logic                        o_idle_ins,
  output logic                        o_err_ins,
  output logic [W_UFL_CNT-1:0]        o_ufl_cnt
);

  localparam int W_BLK = W_DATA * N_TRANS;

  localparam logic [W_SYNC-1:0] SYNC_DATA = W_SYNC'(2'b01);
  localparam logic [W_SYNC-1:0] SYNC_CTRL = W_SYNC'(2'b10);

  // Control blocks, bit 0 first on the wire: block type in [7:0], eight 7-bit codes above it.
  localparam logic [W_BLK-1:0] IDLE_DATA = W_BLK'(64'h0000_0000_0000_001E);
  localparam logic [W_BLK-1:0] ERR_DATA  = W_BLK'({{8{7'h1E}}, 8'h1E});
`ifdef ETH_TX_SCHED_LPI_EN
  localparam logic [W_BLK-1:0] LPI_DATA  = W_BLK'({{8{7'h06}}, 8'h1E});
`endif

  logic [W_SYNC-1:0]    cur_sync_q, cur_sync_d;
  logic [W_BLK-1:0]     cur_data_q, cur_data_d;
  logic                 idle_ins_q, idle_ins_d;
  logic                 err_ins_q,  err_ins_d;
  logic [W_UFL_CNT-1:0] ufl_cnt_q,  ufl_cnt_d;

  logic load_pt;
  logic lpi_hold;
  logic sync_ok;

  // Load point is the last enabled transfer of the block; LPI request blocks the encoder handshake.
  always_comb begin
    load_pt  = i_clk_en && (i_trans_cnt == W_TRANS_PER_BLK'(N_TRANS - 1));
`ifdef ETH_TX_SCHED_LPI_EN
    lpi_hold = i_lpi_req;
`else
    lpi_hold = 1'b0;
`endif
    sync_ok     = (i_blk_sync == SYNC_DATA) || (i_blk_sync == SYNC_CTRL);
    o_blk_ready = load_pt && !lpi_hold;
  end

  // Next block selection: LPI, then encoder block, then error on bad sync, else idle on underflow.
  always_comb begin
    cur_sync_d = cur_sync_q;
    cur_data_d = cur_data_q;
    idle_ins_d = 1'b0;
    err_ins_d  = 1'b0;
    ufl_cnt_d  = ufl_cnt_q;
    if (load_pt) begin
      if (lpi_hold) begin
`ifdef ETH_TX_SCHED_LPI_EN
        cur_sync_d = SYNC_CTRL;
        cur_data_d = LPI_DATA;
`endif
      end else if (i_blk_valid && sync_ok) begin
        cur_sync_d = i_blk_sync;
        cur_data_d = i_blk_data;
      end else if (i_blk_valid) begin
        // Bad sync header: the block is still consumed so the encoder does not stall on it.
        cur_sync_d = SYNC_CTRL;
        cur_data_d = ERR_DATA;
        err_ins_d  = 1'b1;
      end else begin
        cur_sync_d = SYNC_CTRL;
        cur_data_d = IDLE_DATA;
        idle_ins_d = 1'b1;
        if (ufl_cnt_q != '1) begin
          ufl_cnt_d = ufl_cnt_q + 1'b1;
        end
      end
    end
  end

  // Block register and event flops; reset discards any partially sent block.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cur_sync_q <= SYNC_CTRL;
      cur_data_q <= IDLE_DATA;
      idle_ins_q <= 1'b0;
      err_ins_q  <= 1'b0;
      ufl_cnt_q  <= '0;
    end else begin
      cur_sync_q <= cur_sync_d;
      cur_data_q <= cur_data_d;
      idle_ins_q <= idle_ins_d;
      err_ins_q  <= err_ins_d;
      ufl_cnt_q  <= ufl_cnt_d;
    end
  end

  // Word mux follows the gearbox transfer index in the same cycle it is sampled.
  always_comb begin
    o_data = cur_data_q[W_DATA-1:0];
    for (int t = 0; t < N_TRANS; t++) begin
      if (i_trans_cnt == W_TRANS_PER_BLK'(t)) begin
        o_data = cur_data_q[t*W_DATA +: W_DATA];
      end
    end
  end

  assign o_sync_data = cur_sync_q;
  assign o_idle_ins  = idle_ins_q;
  assign o_err_ins   = err_ins_q;
  assign o_ufl_cnt   = ufl_cnt_q;

endmodule

// File: tb/tb_eth_pcs_tx_blk_sched.sv
// Directed bench for eth_pcs_tx_blk_sched: inputs change 1 time unit after posedge, outputs checked at negedge.
module tb_eth_pcs_tx_blk_sched;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_clk_en;
  logic [0:0]  i_trans_cnt;
  logic        i_blk_valid;
  logic [1:0]  i_blk_sync;
  logic [63:0] i_blk_data;
`ifdef ETH_TX_SCHED_LPI_EN
  logic        i_lpi_req;
`endif
  logic        o_blk_ready;
  logic [1:0]  o_sync_data;
  logic [31:0] o_data;
  logic        o_idle_ins;
  logic        o_err_ins;
  logic [15:0] o_ufl_cnt;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  eth_pcs_tx_blk_sched dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clk_en    (i_clk_en),
    .i_trans_cnt (i_trans_cnt),
    .i_blk_valid (i_blk_valid),
    .i_blk_sync  (i_blk_sync),
    .i_blk_data  (i_blk_data),
`ifdef ETH_TX_SCHED_LPI_EN
    .i_lpi_req   (i_lpi_req),
`endif
    .o_blk_ready (o_blk_ready),
    .o_sync_data (o_sync_data),
    .o_data      (o_data),
    .o_idle_ins  (o_idle_ins),
    .o_err_ins   (o_err_ins),
    .o_ufl_cnt   (o_ufl_cnt)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input logic en, input logic tc, input logic vld, input logic [1:0] sy, input logic [63:0] d);
    i_clk_en    = en;
    i_trans_cnt = tc;
    i_blk_valid = vld;
    i_blk_sync  = sy;
    i_blk_data  = d;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
`ifdef ETH_TX_SCHED_LPI_EN
    i_lpi_req = 1'b0;
`endif
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
    #2;
    @(negedge i_clk);
    checks++; if (o_sync_data !== 2'b10) begin errors++; $display("FAIL rst_sync got=%h want=2", o_sync_data); end
    checks++; if (o_data !== 32'h0000_001E) begin errors++; $display("FAIL rst_word0 got=%h want=0000001e", o_data); end
    checks++; if (o_ufl_cnt !== 16'h0) begin errors++; $display("FAIL rst_ufl got=%h want=0", o_ufl_cnt); end
    checks++; if (o_idle_ins !== 1'b0 || o_err_ins !== 1'b0) begin errors++; $display("FAIL rst_pulses got=%b%b want=00", o_idle_ins, o_err_ins); end
    checks++; if (o_blk_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", o_blk_ready); end
    i_trans_cnt = 1'b1;
    #1;
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL rst_word1 got=%h want=0", o_data); end
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_data_stream();
    logic tc;
    logic en;
    set_in(1'b1, 1'b1, 1'b1, 2'b01, 64'hA5A5_0000_FFFF_1234);
    @(negedge i_clk);
    checks++; if (o_blk_ready !== 1'b1) begin errors++; $display("FAIL data_ready got=%b want=1", o_blk_ready); end
    tick();
    tc = 1'b0;
    for (int c = 0; c < 66; c++) begin
      en = (c % 33) != 32;
      i_clk_en    = en;
      i_trans_cnt = tc;
      @(negedge i_clk);
      checks++; if (o_sync_data !== 2'b01) begin errors++; $display("FAIL data_sync c=%0d got=%h want=1", c, o_sync_data); end
      checks++; if (o_data !== (tc ? 32'hA5A5_0000 : 32'hFFFF_1234)) begin errors++; $display("FAIL data_word c=%0d got=%h tc=%0d", c, o_data, tc); end
      checks++; if (o_idle_ins !== 1'b0 || o_err_ins !== 1'b0) begin errors++; $display("FAIL data_pulse c=%0d got=%b%b want=00", c, o_idle_ins, o_err_ins); end
      tick();
      if (en) tc = ~tc;
    end
    i_clk_en = 1'b0;
    @(negedge i_clk);
    checks++; if (o_ufl_cnt !== 16'h0) begin errors++; $display("FAIL data_ufl got=%h want=0", o_ufl_cnt); end
    tick();
  endtask

  task automatic test_underflow();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
      @(negedge i_clk);
      if (o_idle_ins === 1'b1) pulses++;
      if (i > 0) begin
        checks++; if (o_sync_data !== 2'b10 || o_data !== 32'h0000_001E) begin errors++; $display("FAIL ufl_word0 i=%0d got=%h/%h want=2/0000001e", i, o_sync_data, o_data); end
      end
      tick();
      i_trans_cnt = 1'b1;
      @(negedge i_clk);
      if (o_idle_ins === 1'b1) pulses++;
      if (i > 0) begin
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL ufl_word1 i=%0d got=%h want=0", i, o_data); end
      end
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    if (o_idle_ins === 1'b1) pulses++;
    checks++; if (o_sync_data !== 2'b10 || o_data !== 32'h0000_001E) begin errors++; $display("FAIL ufl_last got=%h/%h want=2/0000001e", o_sync_data, o_data); end
    tick();
    @(negedge i_clk);
    if (o_idle_ins === 1'b1) pulses++;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL ufl_pulses got=%0d want=3", pulses); end
    checks++; if (o_ufl_cnt !== 16'd3) begin errors++; $display("FAIL ufl_cnt got=%0d want=3", o_ufl_cnt); end
    tick();
  endtask

  task automatic test_bad_sync();
    set_in(1'b1, 1'b1, 1'b1, 2'b11, 64'hDEAD_BEEF_0BAD_F00D);
    @(negedge i_clk);
    checks++; if (o_blk_ready !== 1'b1) begin errors++; $display("FAIL err_ready got=%b want=1", o_blk_ready); end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    checks++; if (o_sync_data !== 2'b10 || o_data !== 32'hC78F_1E1E) begin errors++; $display("FAIL err_word0 got=%h/%h want=2/c78f1e1e", o_sync_data, o_data); end
    checks++; if (o_err_ins !== 1'b1 || o_idle_ins !== 1'b0) begin errors++; $display("FAIL err_pulse got=%b%b want=10", o_err_ins, o_idle_ins); end
    tick();
    set_in(1'b1, 1'b1, 1'b1, 2'b01, 64'h1111_2222_3333_4444);
    @(negedge i_clk);
    checks++; if (o_data !== 32'h3C78_F1E3) begin errors++; $display("FAIL err_word1 got=%h want=3c78f1e3", o_data); end
    checks++; if (o_err_ins !== 1'b0) begin errors++; $display("FAIL err_single got=%b want=0", o_err_ins); end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    checks++; if (o_sync_data !== 2'b01 || o_data !== 32'h3333_4444) begin errors++; $display("FAIL err_next got=%h/%h want=1/33334444", o_sync_data, o_data); end
    checks++; if (o_err_ins !== 1'b0 || o_ufl_cnt !== 16'd3) begin errors++; $display("FAIL err_after got=%b/%0d want=0/3", o_err_ins, o_ufl_cnt); end
    tick();
  endtask

  task automatic test_pause();
    set_in(1'b0, 1'b1, 1'b1, 2'b01, 64'h5555_6666_7777_8888);
    @(negedge i_clk);
    checks++; if (o_blk_ready !== 1'b0) begin errors++; $display("FAIL pause_ready got=%b want=0", o_blk_ready); end
    checks++; if (o_data !== 32'h1111_2222) begin errors++; $display("FAIL pause_word got=%h want=11112222", o_data); end
    tick();
    i_clk_en = 1'b1;
    @(negedge i_clk);
    checks++; if (o_blk_ready !== 1'b1 || o_data !== 32'h1111_2222) begin errors++; $display("FAIL pause_hold got=%b/%h want=1/11112222", o_blk_ready, o_data); end
    checks++; if (o_idle_ins !== 1'b0) begin errors++; $display("FAIL pause_idle got=%b want=0", o_idle_ins); end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    checks++; if (o_sync_data !== 2'b01 || o_data !== 32'h7777_8888) begin errors++; $display("FAIL pause_word0 got=%h/%h want=1/77778888", o_sync_data, o_data); end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    checks++; if (o_data !== 32'h5555_6666) begin errors++; $display("FAIL pause_word1 got=%h want=55556666", o_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 1'b1, 1'b1, 2'b01, 64'h9999_AAAA_BBBB_CCCC);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    checks++; if (o_data !== 32'hBBBB_CCCC) begin errors++; $display("FAIL rmid_pre got=%h want=bbbbcccc", o_data); end
    #1 i_reset = 1'b1;
    #1;
    checks++; if (o_sync_data !== 2'b10 || o_data !== 32'h0000_001E) begin errors++; $display("FAIL rmid_idle got=%h/%h want=2/0000001e", o_sync_data, o_data); end
    checks++; if (o_ufl_cnt !== 16'h0 || o_idle_ins !== 1'b0) begin errors++; $display("FAIL rmid_ufl got=%h/%b want=0/0", o_ufl_cnt, o_idle_ins); end
    tick();
    i_reset  = 1'b0;
    i_clk_en = 1'b0;
    tick();
    set_in(1'b1, 1'b1, 1'b1, 2'b01, 64'hCAFE_F00D_1357_9BDF);
    @(negedge i_clk);
    checks++; if (o_blk_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b want=1", o_blk_ready); end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    checks++; if (o_sync_data !== 2'b01 || o_data !== 32'h1357_9BDF) begin errors++; $display("FAIL rmid_w0 got=%h/%h want=1/13579bdf", o_sync_data, o_data); end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    checks++; if (o_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rmid_w1 got=%h want=cafef00d", o_data); end
    tick();
  endtask

`ifdef ETH_TX_SCHED_LPI_EN
  task automatic test_lpi();
    i_lpi_req = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 2'b01, 64'h1234_5678_9ABC_DEF0);
    @(negedge i_clk);
    checks++; if (o_blk_ready !== 1'b0) begin errors++; $display("FAIL lpi_ready got=%b want=0", o_blk_ready); end
    tick();
    i_lpi_req = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge i_clk);
    checks++; if (o_sync_data !== 2'b10 || o_data !== 32'hC183_061E) begin errors++; $display("FAIL lpi_w0 got=%h/%h want=2/c183061e", o_sync_data, o_data); end
    checks++; if (o_idle_ins !== 1'b0 || o_ufl_cnt !== 16'h0) begin errors++; $display("FAIL lpi_ufl got=%b/%h want=0/0", o_idle_ins, o_ufl_cnt); end
    i_trans_cnt = 1'b1;
    #1;
    checks++; if (o_data !== 32'h0C18_3060) begin errors++; $display("FAIL lpi_w1 got=%h want=0c183060", o_data); end
    tick();
  endtask
`endif

  task automatic test_saturate();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 2'b00, 64'h0);
    for (int i = 0; i < 65534; i++) tick();
    @(negedge i_clk);
    checks++; if (o_ufl_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h want=fffe", o_ufl_cnt); end
    tick();
    @(negedge i_clk);
    checks++; if (o_ufl_cnt !== 16'hFFFF || o_idle_ins !== 1'b1) begin errors++; $display("FAIL sat_max got=%h/%b want=ffff/1", o_ufl_cnt, o_idle_ins); end
    tick();
    @(negedge i_clk);
    checks++; if (o_ufl_cnt !== 16'hFFFF || o_idle_ins !== 1'b1) begin errors++; $display("FAIL sat_hold got=%h/%b want=ffff/1", o_ufl_cnt, o_idle_ins); end
    i_clk_en = 1'b0;
    tick();
    @(negedge i_clk);
    checks++; if (o_ufl_cnt !== 16'hFFFF || o_idle_ins !== 1'b0) begin errors++; $display("FAIL sat_stop got=%h/%b want=ffff/0", o_ufl_cnt, o_idle_ins); end
    tick();
  endtask

  initial begin
    test_reset();
    test_data_stream();
    test_underflow();
    test_bad_sync();
    test_pause();
    test_reset_mid();
`ifdef ETH_TX_SCHED_LPI_EN
    test_lpi();
`endif
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
